dm_port_arbiter: RTL and testbench

//  Shares the single-port data-memory SRAM (DM1) between two requesters: port 0 = CPU

---
 rtl/dm_port_arbiter.sv | 114 +++++++++++
 tb/tb_dm_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of the single-port data SRAM: the CPU port has priority,
// the secondary port gets a guaranteed slot after STARVE_LIMIT consecutive denied cycles.
module dm_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  input  logic [31:0]           m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic [31:0]           m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  sram_ceb,
  output logic                  sram_web,
  output logic [DATA_W-1:0]     sram_bweb,
  output logic [ADDR_W-1:0]     sram_a,
  output logic [DATA_W-1:0]     sram_di,
  input  logic [DATA_W-1:0]     sram_do,
  output logic [15:0]           conflict_cnt
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {RD_NONE, RD_P0, RD_P1} rd_owner_t;

  rd_owner_t           rd_owner;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                starved;
  logic                sel_we;
  logic [STRB_W-1:0]   sel_wstrb;

  // Byte-offset and high address bits carry no meaning for the word-addressed SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                              m1_addr[31:ADDR_W+2], m1_addr[1:0]};

  assign starved = (wait_cnt == WAIT_W'(STARVE_LIMIT));

  always_comb begin
    m1_gnt = !rst && m1_req && (!m0_req || starved);
    m0_gnt = !rst && m0_req && !m1_gnt;
  end

  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = '1;
    sram_a    = '0;
    sram_di   = '0;
    sel_we    = 1'b0;
    sel_wstrb = '0;
    if (m0_gnt) begin
      sram_ceb  = 1'b0;
      sel_we    = m0_we;
      sel_wstrb = m0_wstrb;
      sram_a    = m0_addr[ADDR_W+1:2];
      sram_di   = m0_wdata;
    end else if (m1_gnt) begin
      sram_ceb  = 1'b0;
      sel_we    = m1_we;
      sel_wstrb = m1_wstrb;
      sram_a    = m1_addr[ADDR_W+1:2];
      sram_di   = m1_wdata;
    end
    sram_web = !(sel_we && !sram_ceb);
    for (int b = 0; b < STRB_W; b++) begin
      sram_bweb[b*8 +: 8] = {8{~(sel_we & sel_wstrb[b])}};
    end
  end

  // Read data from the SRAM lands one cycle after the access; rd_owner steers the valid.
  assign m0_rvalid = !rst && (rd_owner == RD_P0);
  assign m1_rvalid = !rst && (rd_owner == RD_P1);
  assign m0_rdata  = sram_do;
  assign m1_rdata  = sram_do;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner     <= RD_NONE;
      wait_cnt     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (m0_gnt && !m0_we)
        rd_owner <= RD_P0;
      else if (m1_gnt && !m1_we)
        rd_owner <= RD_P1;
      else
        rd_owner <= RD_NONE;

      if (m1_req && !m1_gnt)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;

      if (m0_req && m1_req && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: behavioural SRAM model plus a read-return
// scoreboard checked by a negedge monitor, and one task per scenario.
module tb_dm_port_arbiter;

  localparam int ADDR_W       = 14;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [3:0]        m0_wstrb, m1_wstrb;
  logic [31:0]       m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]       m0_rdata, m1_rdata;
  logic              sram_ceb, sram_web;
  logic [31:0]       sram_bweb, sram_di, sram_do;
  logic [ADDR_W-1:0] sram_a;
  logic [15:0]       conflict_cnt;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  typedef struct {
    int          port;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     sb[$];
  rd_exp_t     mon_e;
  logic        exp0, exp1;
  logic [31:0] mem [0:(1<<ADDR_W)-1];

  dm_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_bweb(sram_bweb), .sram_a(sram_a),
    .sram_di(sram_di), .sram_do(sram_do), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Behavioural single-port SRAM with active-low bit write enables and 1-cycle read.
  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (sram_web)
        sram_do <= mem[sram_a];
      else
        mem[sram_a] <= (mem[sram_a] & sram_bweb) | (sram_di & ~sram_bweb);
    end
  end

  // Read-return monitor: each cycle pops at most one expected return.
  always @(negedge clk) begin
    if (armed) begin
      exp0 = 1'b0;
      exp1 = 1'b0;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        exp0  = (mon_e.port == 0);
        exp1  = (mon_e.port == 1);
      end
      checks++;
      if (m0_rvalid !== exp0 || m1_rvalid !== exp1) begin
        errors++;
        $display("[TB] FAIL rvalid: got m0=%b m1=%b expected m0=%b m1=%b", m0_rvalid, m1_rvalid, exp0, exp1);
      end
      if (exp0 || exp1) begin
        checks++;
        if ((exp0 ? m0_rdata : m1_rdata) !== mon_e.data) begin
          errors++;
          $display("[TB] FAIL rdata_p%0d: got %h expected %h", mon_e.port, exp0 ? m0_rdata : m1_rdata, mon_e.data);
        end
      end
    end
  end

  task automatic drive_m0(input logic req, input logic we, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_wstrb = strb; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_wstrb = strb; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic idle_all();
    drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_m0(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_m1(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_gnt: got m0=%b m1=%b expected 0 0", m0_gnt, m1_gnt);
    end
    checks++;
    if (sram_ceb !== 1'b1 || sram_web !== 1'b1 || sram_bweb !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL reset_sram: got ceb=%b web=%b bweb=%h expected 1 1 ffffffff", sram_ceb, sram_web, sram_bweb);
    end
    checks++;
    if (conflict_cnt !== 16'd0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got cnt=%h rv=%b%b expected 0000 00", conflict_cnt, m0_rvalid, m1_rvalid);
    end
    idle_all();
    @(negedge clk);
    rst   = 1'b0;
    armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    drive_m0(1'b1, 1'b0, 4'hF, 32'h0000_0008, 32'h0);
    #1;
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_gnt: got m0=%b m1=%b expected 1 0", m0_gnt, m1_gnt);
    end
    checks++;
    if (sram_a !== 14'd2 || sram_ceb !== 1'b0 || sram_web !== 1'b1 || sram_bweb !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL read_sram: got a=%0d ceb=%b web=%b bweb=%h expected 2 0 1 ffffffff", sram_a, sram_ceb, sram_web, sram_bweb);
    end
    sb.push_back('{0, 32'hDEAD_BEEF});
    @(negedge clk);
    idle_all();
    #1;
    checks++;
    if (sram_ceb !== 1'b1 || sram_a !== '0 || sram_di !== 32'h0) begin
      errors++;
      $display("[TB] FAIL idle_sram: got ceb=%b a=%0d di=%h expected 1 0 0", sram_ceb, sram_a, sram_di);
    end
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [31:0] w4, w8;
    w4 = init_word(4);
    w8 = init_word(8);
    drive_m0(1'b1, 1'b1, 4'b0011, 32'h0000_0010, 32'h1234_5678);
    #1;
    checks++;
    if (m0_gnt !== 1'b1 || sram_a !== 14'd4 || sram_web !== 1'b0 || sram_ceb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write0_ctl: got gnt=%b a=%0d web=%b ceb=%b expected 1 4 0 0", m0_gnt, sram_a, sram_web, sram_ceb);
    end
    checks++;
    if (sram_bweb !== 32'hFFFF_0000 || sram_di !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL write0_data: got bweb=%h di=%h expected ffff0000 12345678", sram_bweb, sram_di);
    end
    @(negedge clk);
    idle_all();
    drive_m1(1'b1, 1'b1, 4'b1100, 32'h0000_0020, 32'hABCD_EF01);
    #1;
    checks++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || sram_a !== 14'd8 || sram_bweb !== 32'h0000_FFFF || sram_di !== 32'hABCD_EF01) begin
      errors++;
      $display("[TB] FAIL write1: got gnt=%b%b a=%0d bweb=%h di=%h expected 01 8 0000ffff abcdef01", m0_gnt, m1_gnt, sram_a, sram_bweb, sram_di);
    end
    @(negedge clk);
    idle_all();
    drive_m0(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0);
    #1;
    sb.push_back('{0, {w4[31:16], 16'h5678}});
    @(negedge clk);
    idle_all();
    drive_m1(1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0);
    #1;
    sb.push_back('{1, {16'hABCD, w8[15:0]}});
    @(negedge clk);
    idle_all();
    @(negedge clk);
  endtask

  task automatic test_starvation();
    bit exp_m1;
    drive_m0(1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
    drive_m1(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      exp_m1 = (i == 5);
      #1;
      checks++;
      if (m0_gnt !== !exp_m1 || m1_gnt !== exp_m1) begin
        errors++;
        $display("[TB] FAIL starve_gnt_c%0d: got m0=%b m1=%b expected m0=%b m1=%b", i, m0_gnt, m1_gnt, !exp_m1, exp_m1);
      end
      sb.push_back('{exp_m1 ? 1 : 0, exp_m1 ? 32'hDEAD_BEEF : init_word(1)});
      @(negedge clk);
      checks++;
      if (int'(dut.wait_cnt) !== ((i < 5) ? i : i - 5)) begin
        errors++;
        $display("[TB] FAIL starve_wait_c%0d: got %0d expected %0d", i, dut.wait_cnt, (i < 5) ? i : i - 5);
      end
    end
    checks++;
    if (conflict_cnt !== 16'd6) begin
      errors++;
      $display("[TB] FAIL conflict_6: got %0d expected 6", conflict_cnt);
    end
    idle_all();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive_m0(1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0);
    #1;
    sb.push_back('{0, init_word(1)});
    @(negedge clk);
    idle_all();
    drive_m1(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
    #1;
    checks++;
    if (m1_gnt !== 1'b1 || sram_a !== 14'd2) begin
      errors++;
      $display("[TB] FAIL b2b_m1: got gnt=%b a=%0d expected 1 2", m1_gnt, sram_a);
    end
    sb.push_back('{1, 32'hDEAD_BEEF});
    @(negedge clk);
    idle_all();
    drive_m0(1'b1, 1'b0, 4'h0, 32'h0000_000C, 32'h0);
    #1;
    sb.push_back('{0, init_word(3)});
    @(negedge clk);
    idle_all();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    armed = 1'b0;
    drive_m1(1'b1, 1'b0, 4'h0, 32'h0000_0014, 32'h0);
    #1;
    checks++;
    if (m1_gnt !== 1'b1 || sram_ceb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_gnt: got gnt=%b ceb=%b expected 1 0", m1_gnt, sram_ceb);
    end
    @(negedge clk);
    rst = 1'b1;
    drive_m0(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    checks++;
    if (m1_rvalid !== 1'b0 || sram_ceb !== 1'b1 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_rst: got rv=%b ceb=%b gnt=%b%b expected 0 1 00", m1_rvalid, sram_ceb, m0_gnt, m1_gnt);
    end
    @(negedge clk);
    checks++;
    if (int'(dut.wait_cnt) !== 0 || conflict_cnt !== 16'd0 || m1_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_state: got wait=%0d cnt=%0d rv=%b expected 0 0 0", dut.wait_cnt, conflict_cnt, m1_rvalid);
    end
    idle_all();
    rst = 1'b0;
    @(negedge clk);
    sb.delete();
    armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    drive_m0(1'b1, 1'b1, 4'h0, 32'h0, 32'h0);
    drive_m1(1'b1, 1'b1, 4'h0, 32'h0, 32'h0);
    for (int k = 1; k <= 70000; k++) begin
      @(negedge clk);
      if (k == 65534) begin
        checks++;
        if (conflict_cnt !== 16'hFFFE) begin
          errors++;
          $display("[TB] FAIL sat_pre: got %h expected fffe", conflict_cnt);
        end
      end
    end
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL sat_final: got %h expected ffff", conflict_cnt);
    end
    idle_all();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = init_word(i);
    mem[2] = 32'hDEAD_BEEF;
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_starvation();
    test_back_to_back();
    test_reset_abort();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
